// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first, built
// from two cascaded half-subtractor cells; result and borrow land together with DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic hs1_diff, hs1_bor, hs2_bor, bit_diff, bit_bor;
  logic [WIDTH-1:0] res_shifted;

  // First cell handles a-b, second folds in the borrow from the previous bit.
  always_comb begin
    hs1_diff    = a_q[0] ^ b_q[0];
    hs1_bor     = ~a_q[0] & b_q[0];
    bit_diff    = hs1_diff ^ borrow_q;
    hs2_bor     = ~hs1_diff & borrow_q;
    bit_bor     = hs1_bor | hs2_bor;
    res_shifted = {bit_diff, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d      = A;
          b_d      = B;
          res_d    = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = res_shifted;
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = bit_bor;
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = res_shifted;
          bout_d  = bit_bor;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign D    = d_q;
  assign BOUT = bout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port START, input, 1 bit: request to begin a subtraction; level-sampled.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The block SHALL have port D, output, WIDTH bits: registered difference A-B mod 2^WIDTH.
REQ-008 The block SHALL have port BOUT, output, 1 bit: registered final borrow, 1 when A<B.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit: single-cycle pulse marking D/BOUT updated.

Function
REQ-011 The block SHALL implement two states, IDLE and RUN, with all outputs registered.
REQ-012 In IDLE with START=1 at an edge, the block SHALL do all of the following on that edge: capture A and B into internal shift registers, clear the borrow flop and bit counter to 0, enter RUN and set BUSY=1.
REQ-013 In IDLE with START=0, the block SHALL hold state; D and BOUT SHALL keep their last values.
REQ-014 Each RUN edge SHALL process one bit pair LSB-first using two cascaded half-subtractor cells.
REQ-015 The per-bit difference SHALL be a^b^bin.
REQ-016 The per-bit borrow SHALL be (~a&b)|(~(a^b)&bin).
REQ-017 On each RUN edge the block SHALL shift the difference bit into the MSB of the result shift register, shift both operand registers right by 1 and increment the counter.
REQ-018 On the WIDTH-th RUN edge, the block SHALL do all of the following: load D with the completed result, load BOUT with the final borrow, set DONE=1, set BUSY=0 and return to IDLE.
REQ-019 Latency SHALL be exactly WIDTH edges from the capturing edge to DONE asserting; DONE SHALL be high for exactly one cycle.
REQ-020 START while in RUN SHALL be ignored, and A/B changes during RUN SHALL NOT affect the result.
REQ-021 START=1 in the cycle DONE=1 SHALL be accepted (state is IDLE), giving back-to-back operations with no gap cycle.
REQ-022 The counter SHALL be wide enough for WIDTH and SHALL never wrap past WIDTH-1 within an operation.
REQ-023 D and BOUT SHALL change only on the DONE edge or on reset, never mid-operation.

Reset
REQ-024 When RESET_N=0 at an edge, the block SHALL force state=IDLE and D=0, BOUT=0, BUSY=0, DONE=0, and SHALL clear the counter, borrow flop and shift registers.
REQ-025 Reset SHALL take priority over START and over any RUN activity; an operation interrupted by reset SHALL be abandoned with no DONE pulse.
REQ-026 START high on the first edge with RESET_N=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, A=0x05, B=0x03, START 1 cycle -> DONE 8 edges later, D=0x02, BOUT=0, BUSY high for exactly 8 cycles.
REQ-028 A=0x03, B=0x05 -> D=0xFE, BOUT=1; A=0x00, B=0x01 -> D=0xFF, BOUT=1; A=0xFF, B=0xFF -> D=0x00, BOUT=0.
REQ-029 Start A=0x80, B=0x01; at RUN edge 3 change A to 0x00 and pulse START -> START ignored, D=0x7F, BOUT=0, one DONE only.
REQ-030 Start A=0x10, B=0x20; assert RESET_N=0 at RUN edge 4 -> next cycle D=0, BOUT=0, BUSY=0, DONE never pulses; new op A=0x09, B=0x04 -> D=0x05.
REQ-031 Hold START=1 continuously with A=0x0A, B=0x01 -> DONE every 9 cycles, D=0x09 each time, no idle gap between BUSY periods other than the DONE cycle.
REQ-032 Random sweep of 1000 A/B pairs -> {BOUT,D} equals (A-B) mod 2^(WIDTH+1) computed by the model, for WIDTH=8 and WIDTH=4.
